// File: rtl/adder_rs.sv
// Reservation station for the integer adder: captures operands from dispatch and the CDB,
// issues one ready entry at a time and holds the adder inputs until its result wins the CDB.
module adder_rs #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned DATA_W      = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 flush,
  input  logic                                 disp_valid,
  input  logic [5:0]                           disp_opcode,
  input  logic [TAG_W-1:0]                     disp_qj,
  input  logic [DATA_W-1:0]                    disp_vj,
  input  logic [TAG_W-1:0]                     disp_qk,
  input  logic [DATA_W-1:0]                    disp_vk,
  input  logic [TAG_W-1:0]                     disp_dest,
  input  logic [63:0]                          disp_incr_pc,
  input  logic [63:0]                          disp_offset,
  output logic                                 rs_full,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]     rs_count,
  input  logic                                 cdb_valid,
  input  logic [TAG_W-1:0]                     cdb_tag,
  input  logic [DATA_W-1:0]                    cdb_data,
  output logic                                 fu_valid,
  output logic [DATA_W-1:0]                    fu_a,
  output logic [DATA_W-1:0]                    fu_b,
  output logic [63:0]                          fu_opcode,
  output logic [63:0]                          fu_incr_pc,
  output logic [63:0]                          fu_offset,
  output logic [TAG_W-1:0]                     fu_dest,
  input  logic                                 fu_ready,
  input  logic                                 fu_grant
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic [NUM_ENTRIES-1:0]  busy_q, issued_q;
  logic [5:0]              op_q     [NUM_ENTRIES];
  logic [TAG_W-1:0]        qj_q     [NUM_ENTRIES];
  logic [TAG_W-1:0]        qk_q     [NUM_ENTRIES];
  logic [DATA_W-1:0]       vj_q     [NUM_ENTRIES];
  logic [DATA_W-1:0]       vk_q     [NUM_ENTRIES];
  logic [TAG_W-1:0]        dest_q   [NUM_ENTRIES];
  logic [63:0]             ipc_q    [NUM_ENTRIES];
  logic [63:0]             off_q    [NUM_ENTRIES];
  logic [IdxW-1:0]         sel_q;

  logic                    fu_valid_q;
  logic [DATA_W-1:0]       fu_a_q, fu_b_q;
  logic [5:0]              fu_op_q;
  logic [63:0]             fu_ipc_q, fu_off_q;
  logic [TAG_W-1:0]        fu_dest_q;

  logic                    elig_found;
  logic [IdxW-1:0]         free_idx, elig_idx;
  logic [CntW-1:0]         count;
  logic                    disp_fire, cdb_hit;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    elig_found = 1'b0;
    free_idx   = '0;
    elig_idx   = '0;
    count      = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (busy_q[i] && !issued_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        elig_found = 1'b1;
        elig_idx   = IdxW'(i);
      end
      count = count + CntW'(busy_q[i]);
    end
  end

  assign rs_count  = count;
  assign rs_full   = (count == CntW'(NUM_ENTRIES));
  assign disp_fire = disp_valid && !rs_full && !flush;
  assign cdb_hit   = cdb_valid && (cdb_tag != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      busy_q     <= '0;
      issued_q   <= '0;
      sel_q      <= '0;
      fu_valid_q <= 1'b0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_op_q    <= '0;
      fu_ipc_q   <= '0;
      fu_off_q   <= '0;
      fu_dest_q  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        dest_q[i] <= '0;
        ipc_q[i]  <= '0;
        off_q[i]  <= '0;
      end
    end else if (flush) begin
      state_q    <= StIdle;
      busy_q     <= '0;
      issued_q   <= '0;
      fu_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (cdb_hit && busy_q[i]) begin
          if (qj_q[i] == cdb_tag) begin
            vj_q[i] <= cdb_data;
            qj_q[i] <= '0;
          end
          if (qk_q[i] == cdb_tag) begin
            vk_q[i] <= cdb_data;
            qk_q[i] <= '0;
          end
        end
      end

      // The target entry is free in registered state, so it never collides with the snoop above.
      if (disp_fire) begin
        busy_q[free_idx]   <= 1'b1;
        issued_q[free_idx] <= 1'b0;
        op_q[free_idx]     <= disp_opcode;
        dest_q[free_idx]   <= disp_dest;
        ipc_q[free_idx]    <= disp_incr_pc;
        off_q[free_idx]    <= disp_offset;
        if (cdb_hit && disp_qj == cdb_tag) begin
          qj_q[free_idx] <= '0;
          vj_q[free_idx] <= cdb_data;
        end else begin
          qj_q[free_idx] <= disp_qj;
          vj_q[free_idx] <= disp_vj;
        end
        if (cdb_hit && disp_qk == cdb_tag) begin
          qk_q[free_idx] <= '0;
          vk_q[free_idx] <= cdb_data;
        end else begin
          qk_q[free_idx] <= disp_qk;
          vk_q[free_idx] <= disp_vk;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (elig_found) begin
            fu_valid_q         <= 1'b1;
            fu_a_q             <= vj_q[elig_idx];
            fu_b_q             <= vk_q[elig_idx];
            fu_op_q            <= op_q[elig_idx];
            fu_ipc_q           <= ipc_q[elig_idx];
            fu_off_q           <= off_q[elig_idx];
            fu_dest_q          <= dest_q[elig_idx];
            issued_q[elig_idx] <= 1'b1;
            sel_q              <= elig_idx;
            state_q            <= StBusy;
          end
        end
        StBusy: begin
          if (fu_ready && fu_grant) begin
            busy_q[sel_q]   <= 1'b0;
            issued_q[sel_q] <= 1'b0;
            fu_valid_q      <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fu_valid   = fu_valid_q;
  assign fu_a       = fu_a_q;
  assign fu_b       = fu_b_q;
  assign fu_opcode  = {58'd0, fu_op_q};
  assign fu_incr_pc = fu_ipc_q;
  assign fu_offset  = fu_off_q;
  assign fu_dest    = fu_dest_q;

endmodule

// File: tb/tb_adder_rs.sv
// Directed bench for adder_rs: dispatch, CDB capture/bypass, fill/order, flush and async reset.
module tb_adder_rs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        disp_valid;
  logic [5:0]  disp_opcode;
  logic [2:0]  disp_qj, disp_qk, disp_dest;
  logic [63:0] disp_vj, disp_vk, disp_incr_pc, disp_offset;
  logic        rs_full;
  logic [2:0]  rs_count;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        fu_valid;
  logic [63:0] fu_a, fu_b, fu_opcode, fu_incr_pc, fu_offset;
  logic [2:0]  fu_dest;
  logic        fu_ready, fu_grant;

  int checks = 0;
  int errors = 0;

  adder_rs #(.NUM_ENTRIES(4), .TAG_W(3), .DATA_W(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_opcode  (disp_opcode),
    .disp_qj      (disp_qj),
    .disp_vj      (disp_vj),
    .disp_qk      (disp_qk),
    .disp_vk      (disp_vk),
    .disp_dest    (disp_dest),
    .disp_incr_pc (disp_incr_pc),
    .disp_offset  (disp_offset),
    .rs_full      (rs_full),
    .rs_count     (rs_count),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .fu_valid     (fu_valid),
    .fu_a         (fu_a),
    .fu_b         (fu_b),
    .fu_opcode    (fu_opcode),
    .fu_incr_pc   (fu_incr_pc),
    .fu_offset    (fu_offset),
    .fu_dest      (fu_dest),
    .fu_ready     (fu_ready),
    .fu_grant     (fu_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] op, input logic [2:0] qj, input logic [63:0] vj,
                      input logic [2:0] qk, input logic [63:0] vk, input logic [2:0] dest);
    disp_valid   = 1'b1;
    disp_opcode  = op;
    disp_qj      = qj;
    disp_vj      = vj;
    disp_qk      = qk;
    disp_vk      = vk;
    disp_dest    = dest;
    disp_incr_pc = 64'h1004;
    disp_offset  = 64'h40;
  endtask

  task automatic grant_once();
    fu_ready = 1'b1;
    fu_grant = 1'b1;
    tick();
    fu_ready = 1'b0;
    fu_grant = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0;
    disp_qj = '0; disp_qk = '0; disp_dest = '0; disp_vj = '0; disp_vk = '0;
    disp_incr_pc = '0; disp_offset = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    fu_ready = 1'b0; fu_grant = 1'b0;
    #12 reset_n = 1'b1;
    tick();
    check("reset_fu_valid", 64'(fu_valid), 64'd0);
    check("reset_count", 64'(rs_count), 64'd0);
    check("reset_full", 64'(rs_full), 64'd0);
    check("reset_fu_a", fu_a, 64'd0);

    // Ready addq: write at edge 1, issue at edge 2
    disp(6'b010000, 3'd0, 64'd5, 3'd0, 64'd7, 3'd3);
    tick();
    disp_valid = 1'b0;
    check("addq_not_yet", 64'(fu_valid), 64'd0);
    check("addq_count1", 64'(rs_count), 64'd1);
    tick();
    check("addq_valid", 64'(fu_valid), 64'd1);
    check("addq_a", fu_a, 64'd5);
    check("addq_b", fu_b, 64'd7);
    check("addq_op", fu_opcode, 64'h10);
    check("addq_dest", 64'(fu_dest), 64'd3);
    check("addq_ipc", fu_incr_pc, 64'h1004);
    check("addq_off", fu_offset, 64'h40);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    check("addq_hold_no_grant", 64'(fu_valid), 64'd1);
    grant_once();
    check("addq_done_valid", 64'(fu_valid), 64'd0);
    check("addq_done_count", 64'(rs_count), 64'd0);

    // Pending qj captured from the CDB
    disp(6'b010000, 3'd2, 64'hdead, 3'd0, 64'd10, 3'd5);
    tick();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_qj_idle", 64'(fu_valid), 64'd0);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 64'h20;
    tick();
    cdb_valid = 1'b0;
    check("cdb_capture_edge", 64'(fu_valid), 64'd0);
    tick();
    check("cdb_issue", 64'(fu_valid), 64'd1);
    check("cdb_a", fu_a, 64'h20);
    check("cdb_b", fu_b, 64'd10);
    grant_once();

    // Dispatch bypass on qk
    disp(6'b010000, 3'd0, 64'd1, 3'd4, 64'hbad, 3'd6);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 64'd9;
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check("bypass_issue", 64'(fu_valid), 64'd1);
    check("bypass_b", fu_b, 64'd9);
    check("bypass_a", fu_a, 64'd1);
    grant_once();
    tick();
    check("bypass_empty", 64'(rs_count), 64'd0);

    // Fill four entries; entry 0 issues while the rest are still arriving
    for (int i = 0; i < 4; i++) begin
      disp(6'b010000, 3'd0, 64'(100 + i), 3'd0, 64'd0, 3'(i + 1));
      tick();
    end
    check("fill_full", 64'(rs_full), 64'd1);
    check("fill_count", 64'(rs_count), 64'd4);
    check("fill_first_a", fu_a, 64'd100);
    // Full, and the grant frees entry 0 this same cycle: dispatch must still be refused
    disp(6'b010000, 3'd0, 64'd999, 3'd0, 64'd0, 3'd7);
    fu_ready = 1'b1; fu_grant = 1'b1;
    tick();
    disp_valid = 1'b0; fu_ready = 1'b0; fu_grant = 1'b0;
    check("full_blocks_disp", 64'(rs_count), 64'd3);
    check("bubble_0", 64'(fu_valid), 64'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("order_valid", 64'(fu_valid), 64'd1);
      check("order_a", fu_a, 64'(100 + k));
      check("order_dest", 64'(fu_dest), 64'(k + 1));
      grant_once();
      check("order_bubble", 64'(fu_valid), 64'd0);
    end
    tick();
    check("fill_drained", 64'(rs_count), 64'd0);
    check("fill_no_ghost", 64'(fu_valid), 64'd0);

    // Flush while entry 0 is presented, with concurrent dispatch, CDB and grant
    disp(6'b010000, 3'd0, 64'd1, 3'd0, 64'd1, 3'd1);
    tick();
    disp(6'b010000, 3'd0, 64'd2, 3'd0, 64'd2, 3'd2);
    tick();
    check("pre_flush_valid", 64'(fu_valid), 64'd1);
    check("pre_flush_count", 64'(rs_count), 64'd2);
    flush = 1'b1; fu_ready = 1'b1; fu_grant = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 64'h55;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    check("flush_valid", 64'(fu_valid), 64'd0);
    check("flush_count", 64'(rs_count), 64'd0);
    check("flush_full", 64'(rs_full), 64'd0);
    tick();
    tick();
    cdb_valid = 1'b0; fu_ready = 1'b0; fu_grant = 1'b0;
    check("post_flush_valid", 64'(fu_valid), 64'd0);
    check("post_flush_count", 64'(rs_count), 64'd0);

    // Asynchronous reset in the middle of BUSY
    disp(6'b010000, 3'd0, 64'd3, 3'd0, 64'd4, 3'd2);
    tick();
    disp_valid = 1'b0;
    tick();
    check("pre_reset_valid", 64'(fu_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(fu_valid), 64'd0);
    check("async_reset_count", 64'(rs_count), 64'd0);
    check("async_reset_a", fu_a, 64'd0);
    #1 reset_n = 1'b1;
    tick();
    disp(6'b010000, 3'd0, 64'd8, 3'd0, 64'd9, 3'd4);
    tick();
    disp_valid = 1'b0;
    tick();
    check("after_reset_valid", 64'(fu_valid), 64'd1);
    check("after_reset_a", fu_a, 64'd8);
    check("after_reset_b", fu_b, 64'd9);
    check("after_reset_count", 64'(rs_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
